// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module      : run_length_detector
//  Description : Multi-channel detector of consecutive-high runs. Each channel
//                counts consecutive cycles with its detection bit high and
//                flags a hit once a run-time programmable threshold is reached.
//                Level mode holds the hit while the run continues; repeat mode
//                emits one pulse every threshold cycles. A shared saturating
//                counter totals hit events across all channels.
//
//  Ports       : clk        - rising-edge clock
//                rst_a_n    - asynchronous active-low reset (sync release)
//                enable     - 1: channels advance, 0: channel state frozen
//                clear      - synchronous clear of channels and hit_total
//                mode       - 0 level mode, 1 repeat mode (all channels)
//                threshold  - run length that triggers a hit, 0 disables
//                detection  - per-channel detection bits
//                run_count  - per-channel run length, [i*CNT_W +: CNT_W]
//                hit        - per-channel registered hit flag
//                hit_pulse  - per-channel one-cycle pulse on each hit event
//                any_hit    - OR of hit
//                hit_total  - saturating count of hit events
//
//  Revision    : 1.0 - initial release
// ============================================================================
module run_length_detector #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int TOT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_a_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      mode,
    input  logic [CNT_W-1:0]          threshold,
    input  logic [CHANNELS-1:0]       detection,
    output logic [CHANNELS*CNT_W-1:0] run_count,
    output logic [CHANNELS-1:0]       hit,
    output logic [CHANNELS-1:0]       hit_pulse,
    output logic                      any_hit,
    output logic [TOT_W-1:0]          hit_total
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HIT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    // Accumulator is wide enough for a full total plus up to 16 new hits.
    localparam int               c_sum_w   = TOT_W + 5;
    localparam logic [c_sum_w-1:0] c_tot_max = c_sum_w'({TOT_W{1'b1}});

    // ------------------------------------------------------------------------
    // Reset synchroniser: assertion propagates immediately, release is
    // aligned to clk through two flops.
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Next-cycle pulse bits of all channels, feeding the shared total.
    logic [CHANNELS-1:0] w_pulse_all;

    // ------------------------------------------------------------------------
    // Per-channel run tracking
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             r_hit;
        logic             w_hit_nxt;
        logic             r_pulse;
        logic             w_pulse_nxt;
        logic             w_reach;

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_hit_nxt   = r_hit;
            w_pulse_nxt = 1'b0;

            // Saturating increment: a long run parks at the maximum count.
            w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

            // A channel already in HIT keeps qualifying even if the threshold
            // was raised above its count; threshold 0 disables hits entirely.
            w_reach = (threshold != '0) &&
                      ((w_cnt_inc >= threshold) || (r_state == ST_HIT));

            if (clear) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_hit_nxt   = 1'b0;
            end else if (enable) begin
                if (!detection[gi]) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hit_nxt   = 1'b0;
                end else if (w_reach && mode) begin
                    // Repeat mode: reload the run so the next hit comes after
                    // another threshold ones. Count is zero, hence IDLE.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hit_nxt   = 1'b1;
                    w_pulse_nxt = 1'b1;
                end else if (w_reach) begin
                    // Level mode: pulse only on entry into HIT.
                    w_state_nxt = ST_HIT;
                    w_cnt_nxt   = w_cnt_inc;
                    w_hit_nxt   = 1'b1;
                    w_pulse_nxt = (r_state != ST_HIT);
                end else begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = w_cnt_inc;
                    w_hit_nxt   = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_hit   <= 1'b0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_hit   <= w_hit_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        assign w_pulse_all[gi]                = w_pulse_nxt;
        assign run_count[gi*CNT_W +: CNT_W]   = r_cnt;
        assign hit[gi]                        = r_hit;
        assign hit_pulse[gi]                  = r_pulse;
    end

    assign any_hit = |hit;

    // ------------------------------------------------------------------------
    // Shared saturating hit-event total
    // ------------------------------------------------------------------------
    logic [TOT_W-1:0]   r_total;
    logic [TOT_W-1:0]   w_total_nxt;
    logic [c_sum_w-1:0] w_pop;
    logic [c_sum_w-1:0] w_sum;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_pop = w_pop + c_sum_w'(w_pulse_all[i]);
        end
        w_sum       = {5'd0, r_total} + w_pop;
        w_total_nxt = r_total;
        if (clear) begin
            w_total_nxt = '0;
        end else if (enable) begin
            w_total_nxt = (w_sum > c_tot_max) ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_total <= '0;
        end else begin
            r_total <= w_total_nxt;
        end
    end

    assign hit_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_length_detector
//  Description : Self-checking bench for run_length_detector. A behavioural
//                model tracks each channel's run and hit status; a compare
//                process checks every output each cycle, and directed
//                scenarios add hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_detector;

    localparam int CH = 4;
    localparam int CW = 4;
    localparam int TW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int TOT_MAX = (1 << TW) - 1;

    logic             clk = 1'b0;
    logic             rst_a_n = 1'b1;
    logic             enable = 1'b1;
    logic             clear = 1'b0;
    logic             mode = 1'b0;
    logic [CW-1:0]    threshold = 4'd3;
    logic [CH-1:0]    detection = '0;
    logic [CH*CW-1:0] run_count;
    logic [CH-1:0]    hit;
    logic [CH-1:0]    hit_pulse;
    logic             any_hit;
    logic [TW-1:0]    hit_total;

    int n_checks = 0;
    int n_fail   = 0;

    run_length_detector #(.CHANNELS(CH), .CNT_W(CW), .TOT_W(TW)) dut (
        .clk       (clk),
        .rst_a_n   (rst_a_n),
        .enable    (enable),
        .clear     (clear),
        .mode      (mode),
        .threshold (threshold),
        .detection (detection),
        .run_count (run_count),
        .hit       (hit),
        .hit_pulse (hit_pulse),
        .any_hit   (any_hit),
        .hit_total (hit_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: run length as an integer, hit status as flags.
    // ------------------------------------------------------------------------
    int m_run    [CH];
    bit m_held   [CH];   // level-mode hit currently held
    bit m_hit    [CH];
    bit m_pulse  [CH];
    int m_total;
    int m_rel;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_run[c]   = 0;
            m_held[c]  = 0;
            m_hit[c]   = 0;
            m_pulse[c] = 0;
        end
        m_total = 0;
    endtask

    task automatic model_step();
        int thr;
        int nhits;
        int next_run;
        bit reached;
        thr   = int'(threshold);
        nhits = 0;
        if (clear) begin
            model_reset();
        end else if (!enable) begin
            for (int c = 0; c < CH; c++) m_pulse[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                m_pulse[c] = 0;
                if (!detection[c]) begin
                    m_run[c]  = 0;
                    m_held[c] = 0;
                    m_hit[c]  = 0;
                end else begin
                    next_run = (m_run[c] + 1 > CNT_MAX) ? CNT_MAX : m_run[c] + 1;
                    reached  = (thr != 0) && (next_run >= thr || m_held[c]);
                    if (reached && mode) begin
                        m_run[c]   = 0;
                        m_held[c]  = 0;
                        m_hit[c]   = 1;
                        m_pulse[c] = 1;
                    end else if (reached) begin
                        m_pulse[c] = !m_held[c];
                        m_run[c]   = next_run;
                        m_held[c]  = 1;
                        m_hit[c]   = 1;
                    end else begin
                        m_run[c]  = next_run;
                        m_held[c] = 0;
                        m_hit[c]  = 0;
                    end
                end
                nhits += int'(m_pulse[c]);
            end
            m_total = (m_total + nhits > TOT_MAX) ? TOT_MAX : m_total + nhits;
        end
    endtask

    initial begin
        model_reset();
        m_rel = 0;
    end

    // The design's reset release is re-timed through two flops, so the first
    // two edges after release still leave everything in reset.
    always @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            model_reset();
            m_rel = 0;
        end else if (m_rel < 2) begin
            m_rel++;
            model_reset();
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        int any_m;
        any_m = 0;
        for (int c = 0; c < CH; c++) begin
            chk("model run_count", int'(run_count[c*CW +: CW]), m_run[c]);
            chk("model hit", int'(hit[c]), int'(m_hit[c]));
            chk("model hit_pulse", int'(hit_pulse[c]), int'(m_pulse[c]));
            any_m = any_m | int'(m_hit[c]);
        end
        chk("model any_hit", int'(any_hit), any_m);
        chk("model hit_total", int'(hit_total), m_total);
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int cnt_of(input int c);
        return int'(run_count[c*CW +: CW]);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq [9];
        exp_seq = '{1, 2, 0, 1, 2, 0, 1, 2, 0};

        #1 rst_a_n = 1'b0;
        repeat (3) tick();
        chk("reset run_count", int'(run_count), 0);
        chk("reset hit", int'(hit), 0);
        chk("reset any_hit", int'(any_hit), 0);
        chk("reset hit_total", int'(hit_total), 0);
        rst_a_n = 1'b1;
        repeat (4) tick();

        // Level mode, threshold 3, run 1,1,1,0 on channel 0
        mode = 1'b0; threshold = 4'd3; detection = 4'b0001;
        tick(); chk("lvl cnt1", cnt_of(0), 1); chk("lvl hit@1", int'(hit[0]), 0);
        tick(); chk("lvl cnt2", cnt_of(0), 2); chk("lvl hit@2", int'(hit[0]), 0);
        tick(); chk("lvl cnt3", cnt_of(0), 3); chk("lvl hit@3", int'(hit[0]), 1);
        chk("lvl pulse@3", int'(hit_pulse[0]), 1);
        detection = 4'b0000;
        tick(); chk("lvl cnt0", cnt_of(0), 0); chk("lvl hit@4", int'(hit[0]), 0);
        chk("lvl pulse@4", int'(hit_pulse[0]), 0); chk("lvl total", int'(hit_total), 1);

        // Repeat mode, threshold 3, nine ones on channel 1
        mode = 1'b1; detection = 4'b0010;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rpt cnt", cnt_of(1), exp_seq[k]);
            chk("rpt pulse", int'(hit_pulse[1]), (exp_seq[k] == 0) ? 1 : 0);
        end
        chk("rpt total", int'(hit_total), 4);
        detection = 4'b0000; tick();

        // Level mode, threshold 15, twenty ones on channel 2: saturation
        mode = 1'b0; threshold = 4'd15; detection = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("sat cnt", cnt_of(2), (k > 15) ? 15 : k);
            chk("sat hit", int'(hit[2]), (k >= 15) ? 1 : 0);
            chk("sat pulse", int'(hit_pulse[2]), (k == 15) ? 1 : 0);
        end
        detection = 4'b0000; tick();

        // All channels hit together at threshold 2
        threshold = 4'd2; detection = 4'b1111;
        tick(); tick();
        chk("all pulse", int'(hit_pulse), 15);
        chk("all total", int'(hit_total), 9);
        detection = 4'b0000; tick();

        // Drive hit_total to 253 with repeat/threshold 1, then saturate
        mode = 1'b1; threshold = 4'd1; detection = 4'b1111;
        repeat (61) tick();
        chk("pre-sat total", int'(hit_total), 253);
        mode = 1'b0; threshold = 4'd2; detection = 4'b0000; tick();
        detection = 4'b1111; tick(); tick();
        chk("sat total", int'(hit_total), 255);
        tick();
        chk("sat total held", int'(hit_total), 255);
        chk("sat hit held", int'(hit), 15);

        // Clear while hit=1, overriding enable=0 and detection=1
        clear = 1'b1; enable = 1'b0; tick();
        chk("clr run_count", int'(run_count), 0);
        chk("clr hit", int'(hit), 0);
        chk("clr total", int'(hit_total), 0);
        clear = 1'b0; enable = 1'b1; detection = 4'b0000; tick();

        // Freeze with enable=0 at count 2, then resume into a hit
        threshold = 4'd3; detection = 4'b0001;
        tick(); tick();
        enable = 1'b0; detection = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold cnt", cnt_of(0), 2);
            chk("hold hit", int'(hit[0]), 0);
        end
        enable = 1'b1; detection = 4'b0001; tick();
        chk("resume hit", int'(hit[0]), 1);
        chk("resume total", int'(hit_total), 1);
        detection = 4'b0000; tick();

        // Level HIT switching to repeat mode
        threshold = 4'd2; detection = 4'b0001;
        tick(); tick();
        mode = 1'b1; tick();
        chk("mswitch cnt", cnt_of(0), 0); chk("mswitch hit", int'(hit[0]), 1);
        tick();
        chk("mswitch cnt2", cnt_of(0), 1); chk("mswitch hit2", int'(hit[0]), 0);
        mode = 1'b0; detection = 4'b0000; tick();

        // Threshold 0 disables hits, then threshold changes mid-run
        threshold = 4'd0; detection = 4'b1000;
        repeat (5) tick();
        chk("thr0 cnt", cnt_of(3), 5); chk("thr0 hit", int'(hit[3]), 0);
        threshold = 4'd2; tick();
        chk("thr2 cnt", cnt_of(3), 6); chk("thr2 hit", int'(hit[3]), 1);
        threshold = 4'd15; tick();
        chk("raise hit", int'(hit[3]), 1); chk("raise pulse", int'(hit_pulse[3]), 0);
        threshold = 4'd0; tick();
        chk("drop hit", int'(hit[3]), 0); chk("drop cnt", cnt_of(3), 8);
        detection = 4'b0000; tick();

        // Asynchronous reset mid-cycle
        threshold = 4'd3; detection = 4'b0001;
        tick(); tick(); tick();
        chk("pre-rst hit", int'(hit[0]), 1);
        detection = 4'b0000;
        #1 rst_a_n = 1'b0;
        #1;
        chk("async run_count", int'(run_count), 0);
        chk("async hit", int'(hit), 0);
        chk("async any_hit", int'(any_hit), 0);
        chk("async total", int'(hit_total), 0);
        tick(); tick();
        rst_a_n = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
